// File: rtl/copro_pack.sv
// Shared definitions for the floating-point coprocessor: opcodes, FSM states, latency lookup.
package copro_pack;

    localparam logic [10:0] OP_ADD = 11'd0;
    localparam logic [10:0] OP_SUB = 11'd1;
    localparam logic [10:0] OP_MUL = 11'd2;
    localparam logic [10:0] OP_DIV = 11'd3;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Capture-to-result latency for an opcode; anything undecoded completes after one cycle.
    function automatic int unsigned lat_of(input logic [10:0] opcode,
                                           input int unsigned add_lat,
                                           input int unsigned mul_lat,
                                           input int unsigned div_lat);
        case (opcode)
            OP_ADD, OP_SUB: return add_lat;
            OP_MUL:         return mul_lat;
            OP_DIV:         return div_lat;
            default:        return 1;
        endcase
    endfunction

    // All 11 bits take part, so e.g. 0x403 is not a divide.
    function automatic logic is_legal(input logic [10:0] opcode);
        return opcode <= OP_DIV;
    endfunction

endpackage

// File: rtl/float_copro_dp.sv
// Combinational single-precision datapath: add, sub, mul, div.
// Normal numbers only (subnormal inputs read as zero), results truncated toward zero,
// overflow saturates to infinity and underflow flushes to signed zero.
module float_copro_dp
    import copro_pack::*;
(
    input  logic [10:0] opcode_i,
    input  logic [31:0] op0_i,
    input  logic [31:0] op1_i,
    output logic [31:0] result_o
);

    // Assemble a result from sign, unbiased-range exponent and fraction with range clamping.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [22:0] f);
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0)   return {s, 31'd0};
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         d;
        logic [26:0]        mx, my;
        logic [27:0]        s;
        logic signed [9:0]  e;
        int                 pos;
        // x is the larger magnitude, so the sum takes its sign
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (y[30:23] == 8'd0) return (x[30:23] == 8'd0) ? 32'd0 : x;
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = (d > 8'd26) ? 27'd0 : ({1'b1, y[22:0], 3'b000} >> d);
        e  = {2'b00, x[30:23]};
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        if (s == 28'd0) return 32'd0;
        if (s[27]) begin
            s = s >> 1;
            e = e + 10'sd1;
        end else begin
            pos = 0;
            for (int i = 0; i < 27; i++) begin
                if (s[i]) pos = i;
            end
            s = s << (26 - pos);
            e = e - 10'(26 - pos);
        end
        return pack(x[31], e, s[25:3]);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [24:0]        p;
        logic signed [9:0]  e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        // keep the product bits from 2^23 upward; lower bits are truncated away
        p = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'sd127;
        if (p[24]) return pack(s, e + 10'sd1, p[23:1]);
        return pack(s, e, p[22:0]);
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [24:0]        q;
        logic signed [9:0]  e;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0) return {s, 31'd0};
        // quotient of 1.x/1.y scaled by 2^24 lies in (2^23, 2^25)
        q = 25'(48'({1'b1, a[22:0], 24'd0}) / 48'({1'b1, b[22:0]}));
        e = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'sd127;
        if (q[24]) return pack(s, e, q[23:1]);
        return pack(s, e - 10'sd1, q[22:0]);
    endfunction

    // Opcode select; undecoded opcodes produce zero.
    always_comb begin
        result_o = 32'd0;
        case (opcode_i)
            OP_ADD:  result_o = fadd(op0_i, op1_i);
            OP_SUB:  result_o = fadd(op0_i, {~op1_i[31], op1_i[30:0]});
            OP_MUL:  result_o = fmul(op0_i, op1_i);
            OP_DIV:  result_o = fdiv(op0_i, op1_i);
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/float_copro_ctrl.sv
// LM32 user-instruction responder: captures a request, waits the per-opcode latency while the
// registered operands settle through float_copro_dp, then returns the result with a one-cycle
// completion pulse and counts completed operations.
module float_copro_ctrl
    import copro_pack::*;
#(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             user_valid,
    input  logic [10:0]      user_opcode,
    input  logic [31:0]      user_operand_0,
    input  logic [31:0]      user_operand_1,
    output logic [31:0]      user_result,
    output logic             user_complete,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_done
);

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [10:0]        opcode_q, opcode_d;
    logic [31:0]        op0_q, op0_d;
    logic [31:0]        op1_q, op1_d;
    logic [31:0]        result_q, result_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;
    logic [31:0]        dp_result;

    float_copro_dp u_dp (
        .opcode_i (opcode_q),
        .op0_i    (op0_q),
        .op1_i    (op1_q),
        .result_o (dp_result)
    );

    // Next-state: capture in IDLE, count down in BUSY, publish in DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opcode_d   = opcode_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        result_d   = result_q;
        ops_done_d = ops_done_q;
        unique case (state_q)
            StIdle: begin
                if (user_valid) begin
                    opcode_d = user_opcode;
                    op0_d    = user_operand_0;
                    op1_d    = user_operand_1;
                    cnt_d    = lat_of(user_opcode, ADD_LAT, MUL_LAT, DIV_LAT) - 32'd1;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    result_d = is_legal(opcode_q) ? dp_result : 32'd0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                ops_done_d = ops_done_q + CNT_W'(1);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 32'd0;
            opcode_q   <= 11'd0;
            op0_q      <= 32'd0;
            op1_q      <= 32'd0;
            result_q   <= 32'd0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opcode_q   <= opcode_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            result_q   <= result_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign user_result   = result_q;
    assign user_complete = (state_q == StDone);
    assign busy_o        = (state_q != StIdle);
    assign ops_done      = ops_done_q;

    a_lat_min: assert property (@(posedge clk_i)
        (ADD_LAT >= 1) && (MUL_LAT >= 1) && (DIV_LAT >= 1));

    a_single_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        user_complete |=> !user_complete);

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Directed bench for float_copro_ctrl: reset/idle, add, back-to-back sub+mul, div with operand
// churn, illegal opcode, and reset abort followed by a clean request.
module tb_float_copro_ctrl;

    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [10:0] opc;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        complete;
    logic        busy;
    logic [31:0] ops_done;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    float_copro_ctrl #(
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .user_valid     (valid),
        .user_opcode    (opc),
        .user_operand_0 (a),
        .user_operand_1 (b),
        .user_result    (result),
        .user_complete  (complete),
        .busy_o         (busy),
        .ops_done       (ops_done)
    );

    always #5 clk = ~clk;

    // complete is sampled before the edge updates it, i.e. the value of the cycle just ending
    always @(posedge clk) if (complete) pulses <= pulses + 1;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request and wait (bounded) for completion; cycle count n starts at the capture edge.
    task automatic do_op(input string tag, input logic [10:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int lat, input logic [31:0] exp_res,
                         input bit churn);
        int n;
        opc   = o;
        a     = x;
        b     = y;
        valid = 1'b1;
        step();
        n = 1;
        while (!complete && n < 40) begin
            if (churn) begin
                a = $urandom;
                b = $urandom;
            end
            step();
            n++;
        end
        chk({tag, "_latency"}, n, lat + 1);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        opc   = 11'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) step();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_complete", {31'd0, complete}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_result", result, 32'd0);
            chk("idle_ops_done", ops_done, 32'd0);
        end

        // 1.5 + 2.25 = 3.75
        do_op("add", 11'd0, 32'h3FC00000, 32'h40100000, ADD_LAT, 32'h40700000, 1'b0);
        valid = 1'b0;
        step();
        chk("add_single_pulse", {31'd0, complete}, 32'd0);
        chk("add_ops_done", ops_done, 32'd1);
        chk("add_result_hold", result, 32'h40700000);
        chk("add_idle_after", {31'd0, busy}, 32'd0);

        // 3.75 - 1.5 = 2.25, then 2 * 3 = 6 with valid held throughout
        p0 = pulses;
        do_op("sub", 11'd1, 32'h40700000, 32'h3FC00000, ADD_LAT, 32'h40100000, 1'b0);
        opc = 11'd2;
        a   = 32'h40000000;
        b   = 32'h40400000;
        step();
        chk("b2b_idle_gap_busy", {31'd0, busy}, 32'd0);
        chk("b2b_ops_done_sub", ops_done, 32'd2);
        do_op("mul", 11'd2, 32'h40000000, 32'h40400000, MUL_LAT, 32'h40C00000, 1'b0);
        valid = 1'b0;
        step();
        chk("b2b_ops_done_mul", ops_done, 32'd3);
        chk("b2b_pulses", pulses - p0, 32'd2);

        // 6 / 2 = 3 while the operand inputs are scrambled during BUSY
        do_op("div", 11'd3, 32'h40C00000, 32'h40000000, DIV_LAT, 32'h40400000, 1'b1);
        valid = 1'b0;
        step();
        chk("div_ops_done", ops_done, 32'd4);

        // 0x403 is illegal: latency 1, zero result
        do_op("illegal", 11'h403, 32'h40C00000, 32'h40000000, 1, 32'h00000000, 1'b0);
        valid = 1'b0;
        step();
        chk("illegal_ops_done", ops_done, 32'd5);

        // reset during a divide aborts it silently
        p0    = pulses;
        opc   = 11'd3;
        a     = 32'h40C00000;
        b     = 32'h40000000;
        valid = 1'b1;
        repeat (3) step();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        valid = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_complete", {31'd0, complete}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ops_done", ops_done, 32'd0);
        repeat (12) step();
        chk("rst_no_pulse", pulses - p0, 32'd0);

        do_op("add_after_rst", 11'd0, 32'h3FC00000, 32'h40100000, ADD_LAT, 32'h40700000, 1'b0);
        valid = 1'b0;
        step();
        chk("add_after_rst_ops_done", ops_done, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
